weight_feeder: RTL

WEIGHT_FEEDER -- requirements
Module: weight_feeder

---
 rtl/weight_feeder.sv | 185 ++++++++++++++++++
 1 files changed

// File: rtl/weight_feeder.sv
// Weight feeder: buffers packed weight groups in a small FIFO and issues one
// group per enabled cycle to the downstream weight mux for the length of a tile.
// Issue outputs are registered; idle cycles present all-zero bubbles.
module weight_feeder #(
    parameter int unsigned DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       start,
    input  logic [7:0]                 tile_len,
    input  logic                       pe_en,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [31:0]                in_data,
    input  logic                       in_outlier,
    input  logic [5:0]                 in_addr,
    output logic [3:0]                 weight_0,
    output logic [3:0]                 weight_1,
    output logic [3:0]                 weight_2,
    output logic [3:0]                 weight_3,
    output logic [3:0]                 weight_4,
    output logic [3:0]                 weight_5,
    output logic [3:0]                 weight_6,
    output logic [3:0]                 weight_7,
    output logic                       sel,
    output logic [5:0]                 addr,
    output logic                       grp_valid,
    output logic                       w_valid_o,
    output logic                       busy,
    output logic                       done,
    output logic [$clog2(DEPTH):0]     fifo_cnt
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;
    localparam int unsigned EW = 32 + 1 + 6;

    typedef enum logic [1:0] {
        S_IDLE,
        S_STREAM,
        S_FLUSH
    } state_t;

    state_t          state;
    logic [7:0]      issue_cnt;
    logic [7:0]      tile_len_q;
    logic            flush_cnt;

    logic [EW-1:0]   mem [DEPTH];
    logic [AW-1:0]   wr_ptr;
    logic [AW-1:0]   rd_ptr;
    logic [EW-1:0]   rd_entry;

    logic            push;
    logic            pop;

    logic [31:0]     wdata_q;
    logic            wv_d1;
    logic            wv_d2;

    // Full flag comes from registered occupancy only, so a full FIFO never
    // accepts a word in the same cycle that it is popped.
    assign in_ready = (fifo_cnt != CW'(DEPTH));
    assign push     = in_valid && in_ready;
    assign pop      = (state == S_STREAM) && (fifo_cnt != '0) && pe_en;
    assign rd_entry = mem[rd_ptr];
    assign busy     = (state != S_IDLE);

    // FIFO storage; contents need no reset since pointers define validity.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= {in_data, in_outlier, in_addr};
        end
    end

    // FIFO pointers and occupancy; pointers wrap naturally as DEPTH is a power of two.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            fifo_cnt <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({push, pop})
                2'b10:   fifo_cnt <= fifo_cnt + CW'(1);
                2'b01:   fifo_cnt <= fifo_cnt - CW'(1);
                default: fifo_cnt <= fifo_cnt;
            endcase
        end
    end

    // Tile control FSM: counts issued groups, then drains two cycles before done.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            issue_cnt  <= '0;
            tile_len_q <= '0;
            flush_cnt  <= 1'b0;
            done       <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        if (tile_len != 8'd0) begin
                            issue_cnt  <= '0;
                            tile_len_q <= tile_len;
                            state      <= S_STREAM;
                        end else begin
                            done <= 1'b1;
                        end
                    end
                end
                S_STREAM: begin
                    if (pop) begin
                        issue_cnt <= issue_cnt + 8'd1;
                        if (issue_cnt + 8'd1 == tile_len_q) begin
                            flush_cnt <= 1'b0;
                            state     <= S_FLUSH;
                        end
                    end
                end
                S_FLUSH: begin
                    flush_cnt <= 1'b1;
                    if (flush_cnt) begin
                        flush_cnt <= 1'b0;
                        done      <= 1'b1;
                        state     <= S_IDLE;
                    end
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

    // Registered issue stage: a popped group appears one cycle later, else a zero bubble.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wdata_q   <= '0;
            sel       <= 1'b0;
            addr      <= '0;
            grp_valid <= 1'b0;
        end else if (pop) begin
            wdata_q   <= rd_entry[EW-1 -: 32];
            sel       <= rd_entry[6];
            addr      <= rd_entry[6] ? rd_entry[5:0] : 6'd0;
            grp_valid <= 1'b1;
        end else begin
            wdata_q   <= '0;
            sel       <= 1'b0;
            addr      <= '0;
            grp_valid <= 1'b0;
        end
    end

    // Two-stage valid delay matching the downstream weight mux latency.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wv_d1 <= 1'b0;
            wv_d2 <= 1'b0;
        end else begin
            wv_d1 <= grp_valid;
            wv_d2 <= wv_d1;
        end
    end

    assign w_valid_o = wv_d2;

    assign weight_0 = wdata_q[3:0];
    assign weight_1 = wdata_q[7:4];
    assign weight_2 = wdata_q[11:8];
    assign weight_3 = wdata_q[15:12];
    assign weight_4 = wdata_q[19:16];
    assign weight_5 = wdata_q[23:20];
    assign weight_6 = wdata_q[27:24];
    assign weight_7 = wdata_q[31:28];

endmodule
